// File: rtl/qspi_resp_pkg.sv
// qspi_resp_pkg: shared command codes, frame phase lengths and FSM state type
// for the quad-SPI RAM responder.
package qspi_resp_pkg;

   localparam logic [7:0] CMD_QREAD    = 8'hEB;
   localparam logic [7:0] CMD_QWRITE   = 8'h38;
   localparam int         CMD_NIBBLES  = 2;
   localparam int         ADDR_NIBBLES = 6;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      RDATA,
      WDATA,
      IGNORE
   } state_e;

endpackage

// File: rtl/qspi_resp_sync.sv
// qspi_resp_sync: two-flop synchronizers for SCK and CS plus edge detection.
// Flops reset low so a CS already low at reset release never looks like a frame start.
module qspi_resp_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic spi_clk_in,
   input  logic spi_cs_n,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_fall,
   output logic cs_rise
);

   logic [2:0] sck_q, sck_d;
   logic [2:0] cs_q, cs_d;

   always_comb begin
      sck_d = {sck_q[1:0], spi_clk_in};
      cs_d  = {cs_q[1:0], spi_cs_n};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_q <= '0;
         cs_q  <= '0;
      end else begin
         sck_q <= sck_d;
         cs_q  <= cs_d;
      end
   end

   // bit 1 is the synchronized level, bit 2 its previous value
   assign sck_rise = sck_q[1] & ~sck_q[2];
   assign sck_fall = ~sck_q[1] & sck_q[2];
   assign cs_fall  = ~cs_q[1] & cs_q[2];
   assign cs_rise  = cs_q[1] & ~cs_q[2];

endmodule

// File: rtl/qspi_ram_responder.sv
// qspi_ram_responder: quad-SPI target decoding EB (read) / 38 (write) frames
// and serving bytes from a local byte-wide store, oversampled in the clk domain.
module qspi_ram_responder
   import qspi_resp_pkg::*;
#(
   parameter int ADDR_W        = 16,
   parameter int DUMMY_NIBBLES = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_clk_in,
   input  logic              spi_cs_n,
   input  logic [3:0]        spi_data_in,
   output logic [3:0]        spi_data_out,
   output logic [3:0]        spi_data_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata
);

   localparam logic [3:0] CMD_LAST   = 4'(CMD_NIBBLES - 1);
   localparam logic [3:0] ADDR_LAST  = 4'(ADDR_NIBBLES - 1);
   localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_NIBBLES - 1);

   logic sck_rise, sck_fall, cs_fall, cs_rise;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        nib_q, nib_d;
   logic              half_q, half_d;
   logic [7:0]        rbyte_q, rbyte_d;
   logic [3:0]        out_q, out_d;
   logic              re_q, re_d;
   logic              we_q, we_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              rd_lat_q, rd_lat_d;

   qspi_resp_sync u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_clk_in (spi_clk_in),
      .spi_cs_n   (spi_cs_n),
      .sck_rise   (sck_rise),
      .sck_fall   (sck_fall),
      .cs_fall    (cs_fall),
      .cs_rise    (cs_rise)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cmd_d    = cmd_q;
      addr_d   = addr_q;
      nib_d    = nib_q;
      half_d   = half_q;
      rbyte_d  = rd_lat_q ? mem_rdata : rbyte_q;
      out_d    = out_q;
      re_d     = 1'b0;
      we_d     = 1'b0;
      wdata_d  = wdata_q;
      rd_lat_d = re_q;
      // a write strobe uses the current address; advance it once the strobe is out
      if (we_q) addr_d = addr_q + ADDR_W'(1);
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = CMD;
               cnt_d   = '0;
               half_d  = 1'b0;
            end
         end
         CMD: begin
            if (sck_rise) begin
               cmd_d = {cmd_q[3:0], spi_data_in};
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == CMD_LAST) begin
                  cnt_d   = '0;
                  state_d = (cmd_d == CMD_QREAD || cmd_d == CMD_QWRITE) ? ADDR : IGNORE;
               end
            end
         end
         ADDR: begin
            if (sck_rise) begin
               addr_d = {addr_q[ADDR_W-5:0], spi_data_in};
               cnt_d  = cnt_q + 4'd1;
               if (cnt_q == ADDR_LAST) begin
                  cnt_d   = '0;
                  half_d  = 1'b0;
                  re_d    = (cmd_q == CMD_QREAD);
                  state_d = (cmd_q == CMD_QREAD) ? DUMMY : WDATA;
               end
            end
         end
         DUMMY: begin
            if (sck_rise) begin
               cnt_d   = cnt_q + 4'd1;
               state_d = (cnt_q == DUMMY_LAST) ? RDATA : DUMMY;
            end
         end
         RDATA: begin
            // high-nibble fall also prefetches the next byte; keep the low nibble aside
            if (sck_fall) begin
               out_d  = half_q ? nib_q : rbyte_q[7:4];
               nib_d  = half_q ? nib_q : rbyte_q[3:0];
               addr_d = half_q ? addr_q : addr_q + ADDR_W'(1);
               re_d   = ~half_q;
               half_d = ~half_q;
            end
         end
         WDATA: begin
            if (sck_rise) begin
               nib_d   = half_q ? nib_q : spi_data_in;
               wdata_d = half_q ? {nib_q, spi_data_in} : wdata_q;
               we_d    = half_q;
               half_d  = ~half_q;
            end
         end
         IGNORE: ;
         default: state_d = IDLE;
      endcase
      if (cs_rise) begin
         state_d = IDLE;
         out_d   = '0;
         half_d  = 1'b0;
         re_d    = 1'b0;
         we_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cmd_q    <= '0;
         addr_q   <= '0;
         nib_q    <= '0;
         half_q   <= 1'b0;
         rbyte_q  <= '0;
         out_q    <= '0;
         re_q     <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rd_lat_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         nib_q    <= nib_d;
         half_q   <= half_d;
         rbyte_q  <= rbyte_d;
         out_q    <= out_d;
         re_q     <= re_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rd_lat_q <= rd_lat_d;
      end
   end

   assign spi_data_out = out_q;
   assign spi_data_oe  = (state_q == RDATA) ? 4'hF : 4'h0;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_we       = we_q;
   assign mem_re       = re_q;

endmodule

// File: tb/tb_qspi_ram_responder.sv
// tb_qspi_ram_responder: randomized quad-SPI frames against a byte-level reference
// memory; write strobes and read nibbles are compared with what the frames imply.
module tb_qspi_ram_responder;

   localparam int DUMMY = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_clk_in = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic [3:0]  spi_data_in = 4'h0;
   logic [3:0]  spi_data_out, spi_data_oe;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata, mem_rdata;
   logic        mem_we, mem_re;

   qspi_ram_responder #(.ADDR_W(16), .DUMMY_NIBBLES(DUMMY)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .spi_clk_in   (spi_clk_in),
      .spi_cs_n     (spi_cs_n),
      .spi_data_in  (spi_data_in),
      .spi_data_out (spi_data_out),
      .spi_data_oe  (spi_data_oe),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_re       (mem_re),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0]  ram [65536];
   logic [23:0] we_log [$];
   int          re_cnt = 0;
   logic        both = 1'b0;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
      if (mem_we) we_log.push_back({mem_addr, mem_wdata});
      if (mem_re) re_cnt <= re_cnt + 1;
      if (mem_we && mem_re) both <= 1'b1;
   end

   logic [7:0]  ref_mem [logic [15:0]];
   logic [15:0] blk_a [$];
   int          blk_n [$];
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nib(input logic [3:0] d, output logic [3:0] io, output logic [3:0] oe);
      spi_data_in = d;
      #45;
      io = spi_data_out;
      oe = spi_data_oe;
      #5 spi_clk_in = 1'b1;
      #50 spi_clk_in = 1'b0;
   endtask

   task automatic hdr(input logic [7:0] c, input logic [23:0] a);
      logic [3:0] io, oe;
      spi_cs_n = 1'b0;
      #50;
      for (int i = 0; i < 2; i++) nib(c[7-4*i -: 4], io, oe);
      for (int i = 0; i < 6; i++) nib(a[23-4*i -: 4], io, oe);
   endtask

   task automatic frame_end;
      #50 spi_cs_n = 1'b1;
      #100;
   endtask

   task automatic do_write(input logic [23:0] a, input int n, input logic [31:0] d);
      logic [3:0]  io, oe;
      logic [7:0]  b;
      logic [15:0] ea;
      we_log.delete();
      hdr(8'h38, a);
      for (int i = 0; i < n; i++) begin
         b = d[8*(n-1-i) +: 8];
         nib(b[7:4], io, oe);
         nib(b[3:0], io, oe);
      end
      frame_end();
      chk("we_count", we_log.size(), n);
      for (int i = 0; i < n; i++) begin
         b  = d[8*(n-1-i) +: 8];
         ea = a[15:0] + 16'(i);
         if (i < we_log.size()) begin
            chk("we_addr", {16'h0, we_log[i][23:8]}, {16'h0, ea});
            chk("we_data", {24'h0, we_log[i][7:0]}, {24'h0, b});
         end
         ref_mem[ea] = b;
      end
      blk_a.push_back(a[15:0]);
      blk_n.push_back(n);
   endtask

   task automatic do_read(input logic [23:0] a, input int n);
      logic [3:0]  io, oe;
      logic [7:0]  e;
      logic [15:0] ea;
      hdr(8'hEB, a);
      for (int i = 0; i < DUMMY; i++) nib(4'($urandom), io, oe);
      chk("dummy_oe", {28'h0, oe}, 32'h0);
      for (int i = 0; i < n; i++) begin
         ea = a[15:0] + 16'(i);
         e  = ref_mem[ea];
         nib(4'h0, io, oe);
         chk("rd_hi", {28'h0, io}, {28'h0, e[7:4]});
         chk("rd_oe", {28'h0, oe}, 32'hF);
         nib(4'h0, io, oe);
         chk("rd_lo", {28'h0, io}, {28'h0, e[3:0]});
      end
      frame_end();
      chk("idle_oe", {28'h0, spi_data_oe}, 32'h0);
   endtask

   task automatic do_ignore(input logic [7:0] c);
      logic [3:0] io, oe, acc;
      int         re0;
      re0 = re_cnt;
      acc = 4'h0;
      we_log.delete();
      hdr(c, 24'($urandom));
      for (int i = 0; i < 8; i++) begin
         nib(4'($urandom), io, oe);
         acc = acc | oe;
      end
      frame_end();
      chk("ign_re", re_cnt - re0, 0);
      chk("ign_we", we_log.size(), 0);
      chk("ign_oe", {28'h0, acc}, 32'h0);
   endtask

   initial begin
      logic [3:0]  io, oe;
      logic [7:0]  c;
      logic [15:0] sa;
      int          k, o;
      #22;
      chk("rst_oe", {28'h0, spi_data_oe}, 32'h0);
      chk("rst_out", {28'h0, spi_data_out}, 32'h0);
      chk("rst_addr", {16'h0, mem_addr}, 32'h0);
      chk("rst_strobes", {30'h0, mem_we, mem_re}, 32'h0);
      rst_n = 1'b1;
      #50;
      do_write(24'h000010, 2, 32'h0000A53C);
      do_read(24'h000010, 2);
      do_write(24'h00FFFF, 2, 32'h00005AC3);
      do_read(24'h00FFFF, 2);
      do_ignore(8'h9F);
      do_read(24'h000010, 2);
      // abort after three nibbles: only the completed byte may be written
      we_log.delete();
      hdr(8'h38, 24'h000200);
      nib(4'h7, io, oe);
      nib(4'hE, io, oe);
      nib(4'h1, io, oe);
      frame_end();
      chk("part_count", we_log.size(), 1);
      if (we_log.size() > 0) chk("part_we", {8'h0, we_log[0]}, 32'h0002007E);
      chk("part_oe", {28'h0, spi_data_oe}, 32'h0);
      ref_mem[16'h0200] = 8'h7E;
      blk_a.push_back(16'h0200);
      blk_n.push_back(1);
      do_read(24'h000200, 1);
      // reset in the middle of read data
      hdr(8'hEB, 24'h000010);
      for (int i = 0; i < DUMMY; i++) nib(4'h0, io, oe);
      nib(4'h0, io, oe);
      chk("pre_rst_hi", {28'h0, io}, 32'hA);
      rst_n = 1'b0;
      #1;
      chk("arst_oe", {28'h0, spi_data_oe}, 32'h0);
      chk("arst_out", {28'h0, spi_data_out}, 32'h0);
      chk("arst_addr", {16'h0, mem_addr}, 32'h0);
      spi_cs_n = 1'b1;
      #100 rst_n = 1'b1;
      #100;
      do_read(24'h000010, 2);
      for (int t = 0; t < 30; t++) begin
         k = $urandom_range(0, 9);
         if (k < 4) begin
            do_write(24'($urandom), $urandom_range(1, 4), $urandom);
         end else if (k < 8) begin
            k  = $urandom_range(0, blk_a.size() - 1);
            o  = $urandom_range(0, blk_n[k] - 1);
            sa = blk_a[k] + 16'(o);
            do_read({8'($urandom), sa}, blk_n[k] - o);
         end else begin
            do c = 8'($urandom); while (c == 8'hEB || c == 8'h38);
            do_ignore(c);
         end
      end
      chk("we_re_excl", {31'h0, both}, 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
